// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan display.
//   NUM_DIGITS  : number of multiplexed digits on the board
//   SEG_BLANK   : all segments / anodes off (active-low)
//   HEX_SEG     : hex nibble -> {dp,g,f,e,d,c,b,a}, active-low, dp off
//   hex_to_seg  : table lookup helper
package seg7_pkg;

  localparam int NUM_DIGITS = 8;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Packed so that HEX_SEG[n] is the pattern for nibble n (entry 0 is rightmost).
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to seven-segment pattern lookup.
//   nibble_i : 4-bit hex value
//   seg_o    : cathodes, active-low, {dp,g,f,e,d,c,b,a}; dp always off
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seg7_scan_display.sv
// Latches the 32-bit syscall print word and shows it as 8 hex digits on a
// multiplexed common-anode seven-segment display.
//   clk      : system clock
//   rst      : asynchronous reset, active-low
//   ledData  : word to display
//   load     : 1-cycle strobe, capture ledData
//   halt     : CPU halted level (used only with HALT_BLINK_EN)
//   seg      : cathodes, active-low, {dp,g,f,e,d,c,b,a}
//   an       : anodes, active-low, an[i] selects digit i (digit 0 rightmost)
// Optional feature: define HALT_BLINK_EN to blink the whole display while halt=1.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ledData,
  input  logic        load,
  input  logic        halt,
  output logic [7:0]  seg,
  output logic [7:0]  an
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [31:0]      shown_q, shown_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       nibble;
  logic [7:0]       digit_seg;
  logic             advance;
  logic             blank_an;

  // The outputs are computed from the current (pre-edge) latch and index, so a
  // load landing on the edge where a new digit appears shows that digit from
  // the old latch for one cycle.
  assign nibble = shown_q[{idx_q, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble_i (nibble),
    .seg_o    (digit_seg)
  );

  always_comb begin
    shown_d = load ? ledData : shown_q;
    advance = (cnt_q == CNT_LAST);
    cnt_d   = advance ? '0 : cnt_q + 1'b1;
    idx_d   = advance ? idx_q + 3'd1 : idx_q;
    an_d    = blank_an ? SEG_BLANK : ~(8'b1 << idx_q);
    seg_d   = digit_seg;
  end

`ifdef HALT_BLINK_EN
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [BLK_W-1:0] bcnt_q, bcnt_d;
  logic             off_q, off_d;

  // Blink starts in the on-phase; dropping halt returns to it immediately.
  always_comb begin
    bcnt_d = bcnt_q;
    off_d  = off_q;
    if (!halt) begin
      bcnt_d = '0;
      off_d  = 1'b0;
    end else if (bcnt_q == BLK_LAST) begin
      bcnt_d = '0;
      off_d  = ~off_q;
    end else begin
      bcnt_d = bcnt_q + 1'b1;
    end
  end

  // Only the anodes are blanked; the scan keeps running underneath.
  assign blank_an = halt & off_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt_q <= '0;
      off_q  <= 1'b0;
    end else begin
      bcnt_q <= bcnt_d;
      off_q  <= off_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = halt ^ (BLINK_DIV == 0);
  assign blank_an   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shown_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      an_q    <= SEG_BLANK;
      seg_q   <= SEG_BLANK;
    end else begin
      shown_q <= shown_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with SCAN_DIV=4, BLINK_DIV=8.
module tb_seg7_scan_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] ledData = '0;
  logic [7:0]  seg;
  logic [7:0]  an;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  seg7_scan_display #(
    .SCAN_DIV  (4),
    .BLINK_DIV (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ledData (ledData),
    .load    (load),
    .halt    (halt),
    .seg     (seg),
    .an      (an)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
      4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
      4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
      4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [7:0] dig_an(input int d);
    return 8'hFF ^ (8'h01 << d);
  endfunction

  // Edge number cyc (1-based since reset release) shows digit ((cyc-1)/4) mod 8.
  function automatic int cur_dig();
    return ((cyc - 1) / 4) % 8;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_word(input string tag, input int n, input logic [31:0] w);
    int d;
    for (int i = 0; i < n; i++) begin
      step();
      d = cur_dig();
      chk({tag, "_an"}, {24'h0, an}, {24'h0, dig_an(d)});
      chk({tag, "_seg"}, {24'h0, seg}, {24'h0, hex7(w[4*d +: 4])});
    end
  endtask

  task automatic do_load(input string tag, input logic [31:0] v, input logic [31:0] old);
    int d;
    ledData = v;
    load    = 1'b1;
    step();
    d = cur_dig();
    chk({tag, "_ld_seg"}, {24'h0, seg}, {24'h0, hex7(old[4*d +: 4])});
    load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp4 [8];
    int d;
    int d5;
    exp4 = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};

    // Reset asserted between edges takes effect at once.
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rst_an", {24'h0, an}, 32'hFF);
    chk("rst_seg", {24'h0, seg}, 32'hFF);
    @(posedge clk);
    #1;
    chk("rst_hold_an", {24'h0, an}, 32'hFF);
    chk("rst_hold_seg", {24'h0, seg}, 32'hFF);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;

    // 1: all zeros shown, full scan of 8 digits.
    run_word("t1", 32, 32'h0);

    // 2: latch 5, observe across a full wrap.
    do_load("t2", 32'h5, 32'h0);
    run_word("t2", 34, 32'h5);

    // 3: ledData changes without load must be ignored.
    do_load("t3", 32'h6, 32'h5);
    ledData = 32'h7;
    run_word("t3", 40, 32'h6);

    // 4: full word, explicit per-digit patterns and dp off.
    do_load("t4", 32'h89ABCDEF, 32'h6);
    ledData = 32'h0;
    for (int i = 0; i < 32; i++) begin
      step();
      d = cur_dig();
      chk("t4_an", {24'h0, an}, {24'h0, dig_an(d)});
      chk("t4_seg", {24'h0, seg}, {24'h0, exp4[d]});
      chk("t4_dp", {31'h0, seg[7]}, 32'h1);
    end

    // 5: load on the edge where a new digit appears -> one stale cycle.
    while (cyc % 4 != 0) step();
    ledData = 32'h11111111;
    load    = 1'b1;
    step();
    load = 1'b0;
    d5 = cur_dig();
    chk("t5_an_adv", {24'h0, an}, {24'h0, dig_an(d5)});
    chk("t5_stale", {24'h0, seg}, {24'h0, exp4[d5]});
    step();
    chk("t5_an_hold", {24'h0, an}, {24'h0, dig_an(d5)});
    chk("t5_new", {24'h0, seg}, 32'hF9);
    run_word("t5", 10, 32'h11111111);

`ifdef HALT_BLINK_EN
    // 6: 8 on, 8 off, repeating; seg keeps scanning.
    halt = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      step();
      d = cur_dig();
      chk("t6_an", {24'h0, an}, (((k - 1) / 8) % 2 == 1) ? 32'hFF : {24'h0, dig_an(d)});
      chk("t6_seg", {24'h0, seg}, 32'hF9);
    end
    halt = 1'b0;
    step();
    chk("t6_resume_an", {24'h0, an}, {24'h0, dig_an(cur_dig())});
    run_word("t6b", 8, 32'h11111111);
`else
    // 6: without the blink option halt must not disturb the scan.
    halt = 1'b1;
    run_word("t6", 20, 32'h11111111);
    halt = 1'b0;
`endif

    // 7: reset mid-scan clears outputs immediately and empties the latch.
    step();
    #2 rst = 1'b0;
    #1;
    chk("t7_rst_an", {24'h0, an}, 32'hFF);
    chk("t7_rst_seg", {24'h0, seg}, 32'hFF);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    step();
    chk("t7_first_an", {24'h0, an}, 32'hFE);
    chk("t7_first_seg", {24'h0, seg}, 32'hC0);
    run_word("t7", 8, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
